// File: rtl/redmule_w_row_feeder.sv
// -----------------------------------------------------------------------------
// redmule_w_row_feeder
//
// Upstream stage of the W buffer. Rows (or scale vectors in quantized mode)
// arrive from the streamer over a valid/ready handshake and are queued in a
// small FIFO. Each time the W buffer asks for a load, the head row is issued
// together with its quantization group index. The block counts accepted and
// loaded rows and pulses done_o once the final row of the job has gone out.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   clear_i            synchronous soft clear (same effect as rst_i)
//   start_i            one-cycle pulse, latches config and starts a job
//   n_rows_i           rows in the job (sampled at start_i)
//   group_size_i       rows per quant group (sampled at start_i, 0 -> 1)
//   dequant_i          quantized mode (sampled at start_i)
//   in_valid_i/in_ready_o/in_data_i   streamer row handshake
//   buf_ready_i        W buffer requests a load this cycle
//   load_o, w_data_o   load strobe and row data to the W buffer
//   gidx_o             group index accompanying the current load
//   dequant_o          latched quantized mode
//   busy_o             job active (RUN or DONE)
//   done_o             one-cycle pulse after the last row is loaded
// -----------------------------------------------------------------------------
module redmule_w_row_feeder #(
    parameter int unsigned DW        = 288,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned GID_WIDTH = 8,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned GW       = (GID_WIDTH > 1) ? $clog2(GID_WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_rows_i,
    input  logic [7:0]       group_size_i,
    input  logic             dequant_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    input  logic             buf_ready_i,
    output logic             load_o,
    output logic [DW-1:0]    w_data_o,
    output logic [GW-1:0]    gidx_o,
    output logic             dequant_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  n_rows_q;
    logic [7:0]        gs_q;
    logic              dequant_q;
    logic [CNT_W-1:0]  accepted_cnt;
    logic [CNT_W-1:0]  loaded_cnt;
    logic [7:0]        grp_cnt;
    logic [GW-1:0]     gidx_q;

    logic [DW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       fifo_cnt;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_full  = (fifo_cnt == (PW+1)'(DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    // No ready bypass: a full FIFO refuses a row even if a pop happens in the
    // same cycle, which keeps in_ready_o independent of buf_ready_i.
    assign in_ready_o = (state == RUN) && !fifo_full && (accepted_cnt < n_rows_q);
    assign load_o     = (state == RUN) && !fifo_empty && buf_ready_i;

    assign push = in_valid_i && in_ready_o;
    assign pop  = load_o;

    assign w_data_o  = mem[rd_ptr];
    assign gidx_o    = gidx_q;
    assign dequant_o = dequant_q;
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);

    // Row storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    // Job control, FIFO bookkeeping, progress counters and group indexing.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= IDLE;
            n_rows_q     <= '0;
            gs_q         <= 8'd1;
            dequant_q    <= 1'b0;
            accepted_cnt <= '0;
            loaded_cnt   <= '0;
            grp_cnt      <= '0;
            gidx_q       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        n_rows_q     <= n_rows_i;
                        gs_q         <= (group_size_i == 8'd0) ? 8'd1 : group_size_i;
                        dequant_q    <= dequant_i;
                        accepted_cnt <= '0;
                        loaded_cnt   <= '0;
                        grp_cnt      <= '0;
                        gidx_q       <= '0;
                        state        <= (n_rows_i == '0) ? DONE : RUN;
                    end
                end

                RUN: begin
                    if (push) begin
                        wr_ptr       <= wr_ptr + PW'(1);
                        accepted_cnt <= accepted_cnt + CNT_W'(1);
                    end
                    if (pop) begin
                        rd_ptr     <= rd_ptr + PW'(1);
                        loaded_cnt <= loaded_cnt + CNT_W'(1);
                    end
                    case ({push, pop})
                        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                        default: fifo_cnt <= fifo_cnt;
                    endcase

                    // gidx_q tags the load in flight, so it only advances
                    // after the last row of a group has been issued.
                    if (pop && dequant_q) begin
                        if (grp_cnt == gs_q - 8'd1) begin
                            grp_cnt <= '0;
                            if (gidx_q == GW'(GID_WIDTH - 1)) begin
                                gidx_q <= '0;
                            end else begin
                                gidx_q <= gidx_q + GW'(1);
                            end
                        end else begin
                            grp_cnt <= grp_cnt + 8'd1;
                        end
                    end

                    if (pop && (loaded_cnt == n_rows_q - CNT_W'(1))) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_w_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_redmule_w_row_feeder
//
// Directed bench for redmule_w_row_feeder. A table of per-cycle vectors covers
// a basic job and a zero-row job; hand-written sequences cover group index
// sequencing and wrap, backpressure, stream starvation, abort and over-supply.
// Inputs change on the falling edge and outputs are compared 1 time unit later,
// well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_redmule_w_row_feeder;

    localparam int unsigned DW        = 288;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned GID_WIDTH = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned GW        = 3;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             start;
    logic [CNT_W-1:0] n_rows;
    logic [7:0]       group_size;
    logic             dequant;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             buf_ready;
    logic             load;
    logic [DW-1:0]    w_data;
    logic [GW-1:0]    gidx;
    logic             dequant_out;
    logic             busy;
    logic             done;

    int errors;
    int checks;
    int gtab [32];

    redmule_w_row_feeder #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .GID_WIDTH (GID_WIDTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .start_i      (start),
        .n_rows_i     (n_rows),
        .group_size_i (group_size),
        .dequant_i    (dequant),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .buf_ready_i  (buf_ready),
        .load_o       (load),
        .w_data_o     (w_data),
        .gidx_o       (gidx),
        .dequant_o    (dequant_out),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        start;
        logic        clear;
        logic [15:0] n;
        logic [7:0]  gs;
        logic        dq;
        logic        valid;
        logic [31:0] word;
        logic        bready;
        logic        e_ready;
        logic        e_load;
        logic [31:0] e_word;
        logic [2:0]  e_gidx;
        logic        e_busy;
        logic        e_done;
        logic        e_dq;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic [15:0] n,
                                 input logic [7:0] g, input logic d, input logic v,
                                 input logic [31:0] w, input logic b);
        @(negedge clk);
        start      = s;
        clear      = c;
        n_rows     = n;
        group_size = g;
        dequant    = d;
        in_valid   = v;
        in_data    = {9{w}};
        buf_ready  = b;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic e_ready, input logic e_load,
                               input logic [31:0] e_word, input logic [2:0] e_gidx,
                               input logic e_busy, input logic e_done, input logic e_dq);
        chk({tag, " ready"}, DW'(in_ready), DW'(e_ready));
        chk({tag, " load"},  DW'(load),     DW'(e_load));
        chk({tag, " busy"},  DW'(busy),     DW'(e_busy));
        chk({tag, " done"},  DW'(done),     DW'(e_done));
        if (e_load) begin
            chk({tag, " data"}, w_data,     {9{e_word}});
            chk({tag, " gidx"}, DW'(gidx),  DW'(e_gidx));
        end
        if (e_busy) begin
            chk({tag, " dequant"}, DW'(dequant_out), DW'(e_dq));
        end
    endtask

    // Full-throughput job: streamer always valid, buffer always ready.
    // Expected group index for load k comes from gtab[k].
    task automatic runStream(input string tag, input logic [15:0] n, input logic [7:0] gs,
                             input logic dq, input logic [31:0] base);
        int r;
        logic [2:0] eg;
        r = 0;
        applyStimulus(1'b1, 1'b0, n, gs, dq, 1'b0, base, 1'b1);
        checkOutput($sformatf("%s c0", tag), 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= int'(n) + 1; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, (c <= int'(n)), base + 32'(r), 1'b1);
            eg = (c >= 2 && dq) ? 3'(gtab[c-2]) : 3'd0;
            checkOutput($sformatf("%s c%0d", tag, c), (c <= int'(n)), (c >= 2),
                        base + 32'(c - 2), eg, 1'b1, 1'b0, dq);
            if (in_valid && in_ready) r++;
        end
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput($sformatf("%s done", tag), 1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, dq);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput($sformatf("%s idle", tag), 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl [11];
    int   exp_g [10];
    int   bp_rdy [10];
    int   sv_rdy [7];
    int   os_rdy [11];
    int   r;
    int   hs;

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        clear      = 1'b0;
        start      = 1'b0;
        n_rows     = '0;
        group_size = '0;
        dequant    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        buf_ready  = 1'b0;

        // Basic 4-row job (loads in c2..c5, done in c6) then a zero-row job.
        tbl[0]  = '{1'b1,1'b0,16'd4,8'd1,1'b0,1'b1,32'hA0000000,1'b1, 1'b0,1'b0,32'h0,        3'd0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000000,1'b1, 1'b1,1'b0,32'h0,        3'd0,1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000001,1'b1, 1'b1,1'b1,32'hA0000000,3'd0,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000002,1'b1, 1'b1,1'b1,32'hA0000001,3'd0,1'b1,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000003,1'b1, 1'b1,1'b1,32'hA0000002,3'd0,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000004,1'b1, 1'b0,1'b1,32'hA0000003,3'd0,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000004,1'b1, 1'b0,1'b0,32'h0,        3'd0,1'b1,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b0,32'h0,       1'b1, 1'b0,1'b0,32'h0,        3'd0,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b0,16'd0,8'd1,1'b0,1'b1,32'hA0000005,1'b1, 1'b0,1'b0,32'h0,        3'd0,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b1,32'hA0000005,1'b1, 1'b0,1'b0,32'h0,        3'd0,1'b1,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,16'd0,8'd0,1'b0,1'b0,32'h0,       1'b1, 1'b0,1'b0,32'h0,        3'd0,1'b0,1'b0,1'b0};

        exp_g  = '{0,0,0,1,1,1,2,2,2,3};
        bp_rdy = '{0,1,1,0,0,0,0,1,1,0};
        sv_rdy = '{0,1,1,1,1,1,0};
        os_rdy = '{0,1,1,0,1,0,0,0,0,0,0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset ready",   DW'(in_ready),    DW'(1'b0));
        chk("reset load",    DW'(load),        DW'(1'b0));
        chk("reset gidx",    DW'(gidx),        DW'(3'd0));
        chk("reset dequant", DW'(dequant_out), DW'(1'b0));
        chk("reset busy",    DW'(busy),        DW'(1'b0));
        chk("reset done",    DW'(done),        DW'(1'b0));
        rst = 1'b0;

        $display("[TB] table: basic job and zero-row job");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].start, tbl[i].clear, tbl[i].n, tbl[i].gs, tbl[i].dq,
                          tbl[i].valid, tbl[i].word, tbl[i].bready);
            checkOutput($sformatf("tbl%0d", i), tbl[i].e_ready, tbl[i].e_load, tbl[i].e_word,
                        tbl[i].e_gidx, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_dq);
        end

        $display("[TB] group index: 10 rows, group size 3");
        for (int k = 0; k < 32; k++) gtab[k] = 0;
        for (int k = 0; k < 10; k++) gtab[k] = exp_g[k];
        runStream("grp10", 16'd10, 8'd3, 1'b1, 32'hB0000000);

        $display("[TB] group index wrap: 27 rows, group size 3");
        for (int k = 0; k < 27; k++) gtab[k] = (k / 3) % 8;
        runStream("grp27", 16'd27, 8'd3, 1'b1, 32'hC0000000);
        chk("grp27 load25 gidx table", DW'(gtab[24]), DW'(0));

        $display("[TB] backpressure: 4 rows, buffer stalled 5 cycles");
        applyStimulus(1'b1, 1'b0, 16'd4, 8'd1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("bp c0", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        r = 0;
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, (r < 4), 32'hD0000000 + 32'(r), (c >= 6));
            checkOutput($sformatf("bp c%0d", c), bp_rdy[c] != 0, (c >= 6),
                        32'hD0000000 + 32'(c - 6), 3'd0, 1'b1, 1'b0, 1'b0);
            if (in_valid && in_ready) r++;
        end
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp done", 1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp idle", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] starvation: 3 rows, valid toggling");
        applyStimulus(1'b1, 1'b0, 16'd3, 8'd1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("sv c0", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        r = 0;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, (c % 2 == 1), 32'hE0000000 + 32'(r), 1'b1);
            checkOutput($sformatf("sv c%0d", c), sv_rdy[c] != 0, (c % 2 == 0),
                        32'hE0000000 + 32'(c / 2 - 1), 3'd0, 1'b1, 1'b0, 1'b0);
            if (in_valid && in_ready) r++;
        end
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("sv done", 1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("sv idle", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] abort: clear after 2 of 6 loads");
        applyStimulus(1'b1, 1'b0, 16'd6, 8'd1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("ab c0", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'hF0000000, 1'b1);
        checkOutput("ab c1", 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'hF0000001, 1'b1);
        checkOutput("ab c2", 1'b1, 1'b1, 32'hF0000000, 3'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'hF0000002, 1'b1);
        checkOutput("ab c3", 1'b1, 1'b1, 32'hF0000001, 3'd1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("ab clear", 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        checkOutput("ab c5", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("ab c5 gidx",    DW'(gidx),        DW'(3'd0));
        chk("ab c5 dequant", DW'(dequant_out), DW'(1'b0));
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("ab c6", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        gtab[0] = 0;
        gtab[1] = 1;
        runStream("ab fresh", 16'd2, 8'd1, 1'b1, 32'h12340000);

        $display("[TB] over-supply: 3 rows, valid held 10 cycles");
        applyStimulus(1'b1, 1'b0, 16'd3, 8'd1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("os c0", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        r  = 0;
        hs = 0;
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'h55000000 + 32'(r), (c == 3));
            checkOutput($sformatf("os c%0d", c), os_rdy[c] != 0, (c == 3),
                        32'h55000000, 3'd0, 1'b1, 1'b0, 1'b0);
            if (in_valid && in_ready) begin
                r++;
                hs++;
            end
        end
        for (int c = 11; c <= 12; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("os c%0d", c), 1'b0, 1'b1,
                        32'h55000000 + 32'(c - 10), 3'd0, 1'b1, 1'b0, 1'b0);
        end
        chk("os handshakes", DW'(hs), DW'(3));
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        checkOutput("os done", 1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1, 32'h0, 1'b1);
        checkOutput("os idle", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
